// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMAC AXI read-address path.
package dmac_pkg;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         DMAC_LEN_W     = 4;

  typedef struct packed {
    logic [31:0]           addr;
    logic [DMAC_LEN_W-1:0] len;
  } ar_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmac_rr_pick.sv
// Round-robin first-one finder: scans eligible requesters starting at i_rr_ptr.
module dmac_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_eligible,
  input  logic [PTR_W-1:0] i_rr_ptr,
  output logic [N-1:0]     o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  // Wrap-around scan; the first hit after the pointer wins.
  always_comb begin
    logic [PTR_W-1:0] j;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      j = PTR_W'((int'(i_rr_ptr) + k) % N);
      if (!o_any && i_eligible[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = j;
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/dmac_ar_credit_arbiter.sv
// Credit-aware round-robin scheduler sharing one AXI AR port among N_REQ initiators;
// a burst issues only when its requester is under MAX_OUTS and every beat has FIFO space.
module dmac_ar_credit_arbiter
  import dmac_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int ID_W         = 4,
  parameter int LEN_W        = 4,
  parameter int MAX_OUTS     = 2,
  parameter int BEAT_CREDITS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*32-1:0]    req_addr_i,
  input  logic [N_REQ*LEN_W-1:0] req_len_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic                   arvalid_o,
  input  logic                   arready_i,
  output logic [ID_W-1:0]        arid_o,
  output logic [31:0]            araddr_o,
  output logic [LEN_W-1:0]       arlen_o,
  input  logic                   r_hs_i,
  input  logic [ID_W-1:0]        rid_i,
  input  logic                   rlast_i,
  input  logic                   beat_free_i,
  output logic                   idle_o,
  output logic                   err_o
);

  localparam int PTR_W  = idx_width(N_REQ);
  localparam int CRD_W  = $clog2(BEAT_CREDITS + 1);
  localparam int OUT_W  = $clog2(MAX_OUTS + 1);
  localparam int NEED_W = (CRD_W > LEN_W + 1) ? CRD_W : LEN_W + 1;
  localparam int SUM_W  = NEED_W + 1;
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(BEAT_CREDITS);
  localparam logic [OUT_W-1:0] OUTS_MAX = OUT_W'(MAX_OUTS);

  arb_state_e r_state, w_state_nxt;

  logic [PTR_W-1:0]       r_rr_ptr, r_gidx, w_idx;
  logic [N_REQ-1:0]       r_gnt, w_grant;
  logic [ID_W-1:0]        r_arid;
  logic [31:0]            r_araddr;
  logic [LEN_W-1:0]       r_arlen;
  logic [CRD_W-1:0]       r_credit, w_credit_nxt;
  logic                   r_err;

  logic [N_REQ-1:0]       w_eligible, w_rlast_hit, w_inc, w_dec, w_orphan, w_zero;
  logic [N_REQ*OUT_W-1:0] w_outs;
  logic [SUM_W-1:0]       w_crd_sum;
  logic                   w_any, w_load, w_ar_hs, w_rid_bad, w_crd_ovf, w_err_set;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    logic [OUT_W-1:0] r_cnt;

    assign w_eligible[gi]  = req_valid_i[gi] & (r_cnt < OUTS_MAX) &
                             (NEED_W'(r_credit) >=
                              NEED_W'(req_len_i[LEN_W*gi +: LEN_W]) + NEED_W'(1'b1));
    assign w_rlast_hit[gi] = r_hs_i & rlast_i & (32'(rid_i) == 32'(gi));
    assign w_inc[gi]       = w_ar_hs & r_gnt[gi];
    assign w_dec[gi]       = w_rlast_hit[gi] & (r_cnt != '0);
    assign w_orphan[gi]    = w_rlast_hit[gi] & (r_cnt == '0);
    assign w_zero[gi]      = (r_cnt == '0);
    assign w_outs[gi*OUT_W +: OUT_W] = r_cnt;

    // Issued-but-not-completed bursts; issue and rlast in one cycle cancel out.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + OUT_W'(w_inc[gi]) - OUT_W'(w_dec[gi]);
      end
    end
  end

  dmac_rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_eligible (w_eligible),
    .i_rr_ptr   (r_rr_ptr),
    .o_grant    (w_grant),
    .o_idx      (w_idx),
    .o_any      (w_any)
  );

  assign w_ar_hs = (r_state == ISSUE) & arready_i;

  // Next state: arbitrate only in IDLE, hold the committed grant until ARREADY.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = ISSUE;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (arready_i) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = ISSUE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Credit: reserve len+1 beats at issue, return one per FIFO pop, saturate on excess returns.
  always_comb begin
    w_crd_sum = SUM_W'(r_credit) + SUM_W'(beat_free_i) -
                (w_ar_hs ? (SUM_W'(r_arlen) + SUM_W'(1'b1)) : '0);
    if (w_crd_sum > SUM_W'(CRD_MAX)) begin
      w_credit_nxt = CRD_MAX;
      w_crd_ovf    = 1'b1;
    end else begin
      w_credit_nxt = w_crd_sum[CRD_W-1:0];
      w_crd_ovf    = 1'b0;
    end
  end

  assign w_rid_bad = r_hs_i & rlast_i & (32'(rid_i) >= 32'(N_REQ));
  assign w_err_set = w_rid_bad | (|w_orphan) | w_crd_ovf;

  // FSM state, frozen AR payload, round-robin pointer, credit and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gidx   <= '0;
      r_gnt    <= '0;
      r_arid   <= '0;
      r_araddr <= '0;
      r_arlen  <= '0;
      r_rr_ptr <= '0;
      r_credit <= CRD_MAX;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_gidx   <= w_idx;
        r_gnt    <= w_grant;
        r_arid   <= ID_W'(w_idx);
        r_araddr <= req_addr_i[32*w_idx +: 32];
        r_arlen  <= req_len_i[LEN_W*w_idx +: LEN_W];
      end
      if (w_ar_hs) begin
        r_rr_ptr <= (r_gidx == PTR_W'(N_REQ - 1)) ? '0 : r_gidx + PTR_W'(1'b1);
      end
      r_credit <= w_credit_nxt;
      r_err    <= r_err | w_err_set;
    end
  end

  assign arvalid_o   = (r_state == ISSUE);
  assign arid_o      = r_arid;
  assign araddr_o    = r_araddr;
  assign arlen_o     = r_arlen;
  assign req_ready_o = w_ar_hs ? r_gnt : '0;
  assign idle_o      = (&w_zero) & (r_credit == CRD_MAX) & (r_state == IDLE);
  assign err_o       = r_err;

endmodule

// File: tb/tb_dmac_ar_credit_arbiter.sv
// Scoreboard bench for dmac_ar_credit_arbiter: directed bursts, expected AR beats queued
// by the stimulus and matched by an independent negedge monitor.
module tb_dmac_ar_credit_arbiter;

  localparam int N     = 4;
  localparam int ID_W  = 4;
  localparam int LEN_W = 4;
  localparam int OUT_W = 2;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [31:0]      addr;
    logic [LEN_W-1:0] len;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         req_valid_i = '0;
  logic [N*32-1:0]      req_addr_i = '0;
  logic [N*LEN_W-1:0]   req_len_i = '0;
  logic [N-1:0]         req_ready_o;
  logic                 arvalid_o;
  logic                 arready_i = 1'b0;
  logic [ID_W-1:0]      arid_o;
  logic [31:0]          araddr_o;
  logic [LEN_W-1:0]     arlen_o;
  logic                 r_hs_i = 1'b0;
  logic [ID_W-1:0]      rid_i = '0;
  logic                 rlast_i = 1'b0;
  logic                 beat_free_i = 1'b0;
  logic                 idle_o;
  logic                 err_o;

  int               rem [N];
  logic [31:0]      addr_q [N];
  logic [LEN_W-1:0] len_q [N];
  exp_t             sb [$];
  int               checks = 0;
  int               failures = 0;
  bit               mon_en = 1'b0;
  bit               prev_hs = 1'b0;

  dmac_ar_credit_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_len_i   (req_len_i),
    .req_ready_o (req_ready_o),
    .arvalid_o   (arvalid_o),
    .arready_i   (arready_i),
    .arid_o      (arid_o),
    .araddr_o    (araddr_o),
    .arlen_o     (arlen_o),
    .r_hs_i      (r_hs_i),
    .rid_i       (rid_i),
    .rlast_i     (rlast_i),
    .beat_free_i (beat_free_i),
    .idle_o      (idle_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int outs(input int i);
    logic [N*OUT_W-1:0] v;
    v = dut.w_outs;
    return int'(v[OUT_W*i +: OUT_W]);
  endfunction

  task automatic drive_pins();
    for (int i = 0; i < N; i++) begin
      req_valid_i[i]               = (rem[i] > 0);
      req_addr_i[32*i +: 32]       = addr_q[i];
      req_len_i[LEN_W*i +: LEN_W]  = len_q[i];
    end
  endtask

  // One clock: note accepts mid-cycle, then advance each accepted requester after the edge.
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_ready_o;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] === 1'b1) begin
        if (rem[i] > 0) rem[i]--;
        addr_q[i] = addr_q[i] + 32'h100;
      end
    end
    drive_pins();
  endtask

  task automatic wait_sb(input int target, input int budget, input string name);
    int n = 0;
    while (sb.size() > target && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 64'(sb.size() > target), 64'd0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) rem[i] = 0;
    arready_i   = 1'b0;
    r_hs_i      = 1'b0;
    rlast_i     = 1'b0;
    beat_free_i = 1'b0;
    rst         = 1'b1;
    drive_pins();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input int cnt, input logic [31:0] a, input logic [LEN_W-1:0] l);
    rem[i]    = cnt;
    addr_q[i] = a;
    len_q[i]  = l;
  endtask

  task automatic rlast_pulse(input logic [ID_W-1:0] id);
    r_hs_i  = 1'b1;
    rlast_i = 1'b1;
    rid_i   = id;
    tick();
    r_hs_i  = 1'b0;
    rlast_i = 1'b0;
  endtask

  // Monitor: every AR handshake must match the oldest expected burst.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (arvalid_o === 1'b1 && arready_i === 1'b1) begin
          chk("ar_back_to_back", 64'(prev_hs), 64'd0);
          chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("arid", 64'(arid_o), 64'(e.id));
            chk("araddr", 64'(araddr_o), 64'(e.addr));
            chk("arlen", 64'(arlen_o), 64'(e.len));
            chk("req_ready_onehot", 64'(req_ready_o), 64'(4'b0001 << e.id));
          end
          prev_hs = 1'b1;
        end else begin
          chk("req_ready_quiet", 64'(req_ready_o), 64'd0);
          if (prev_hs) chk("ar_gap", 64'(arvalid_o), 64'd0);
          prev_hs = 1'b0;
        end
      end else begin
        prev_hs = 1'b0;
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) set_req(i, 0, 32'h0, '0);
    drive_pins();
    do_reset();
    mon_en = 1'b1;

    chk("rst_arvalid", 64'(arvalid_o), 64'd0);
    chk("rst_ar_payload", 64'({arid_o, araddr_o, arlen_o}), 64'd0);
    chk("rst_credit", 64'(dut.r_credit), 64'd16);
    chk("rst_idle", 64'(idle_o), 64'd1);
    chk("rst_err", 64'(err_o), 64'd0);

    // Single req0 len=3 with ARREADY tied high.
    arready_i = 1'b1;
    set_req(0, 1, 32'h0000_1000, 4'd3);
    sb.push_back('{id: 4'd0, addr: 32'h0000_1000, len: 4'd3});
    drive_pins();
    tick();
    chk("t1_arvalid_t1", 64'(arvalid_o), 64'd1);
    chk("t1_ready_t1", 64'(req_ready_o), 64'b0001);
    tick();
    chk("t1_credit12", 64'(dut.r_credit), 64'd12);
    chk("t1_outs0", 64'(outs(0)), 64'd1);
    chk("t1_not_idle", 64'(idle_o), 64'd0);
    rlast_pulse(4'd0);
    beat_free_i = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    beat_free_i = 1'b0;
    chk("t1_credit16", 64'(dut.r_credit), 64'd16);
    chk("t1_idle", 64'(idle_o), 64'd1);

    // All four requesters, len=0, two bursts each: order 0,1,2,3,0,1,2,3.
    do_reset();
    arready_i = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 2, 32'h2000 + 32'(i * 16), 4'd0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        sb.push_back('{id: ID_W'(i), addr: 32'h2000 + 32'(i * 16) + 32'(r * 256), len: 4'd0});
    drive_pins();
    wait_sb(0, 40, "t2_rr");
    chk("t2_credit8", 64'(dut.r_credit), 64'd8);
    chk("t2_outs2", 64'(outs(2)), 64'd2);

    // req1 len=15 drains all credit; req2 len=0 waits for a single returned beat.
    do_reset();
    arready_i = 1'b1;
    set_req(1, 1, 32'h0000_3000, 4'd15);
    sb.push_back('{id: 4'd1, addr: 32'h0000_3000, len: 4'd15});
    drive_pins();
    wait_sb(0, 10, "t3_big");
    chk("t3_credit0", 64'(dut.r_credit), 64'd0);
    set_req(2, 1, 32'h0000_3800, 4'd0);
    sb.push_back('{id: 4'd2, addr: 32'h0000_3800, len: 4'd0});
    drive_pins();
    for (int k = 0; k < 3; k++) tick();
    chk("t3_stalled_arvalid", 64'(arvalid_o), 64'd0);
    chk("t3_stalled_pending", 64'(sb.size()), 64'd1);
    beat_free_i = 1'b1;
    tick();
    beat_free_i = 1'b0;
    chk("t3_credit1", 64'(dut.r_credit), 64'd1);
    wait_sb(0, 10, "t3_small");
    chk("t3_credit_back0", 64'(dut.r_credit), 64'd0);

    // MAX_OUTS: third req0 burst waits for an rlast on id 0.
    do_reset();
    arready_i = 1'b1;
    set_req(0, 3, 32'h0000_4000, 4'd0);
    for (int r = 0; r < 3; r++)
      sb.push_back('{id: 4'd0, addr: 32'h0000_4000 + 32'(r * 256), len: 4'd0});
    drive_pins();
    for (int k = 0; k < 8; k++) tick();
    chk("t4_third_held", 64'(sb.size()), 64'd1);
    chk("t4_outs_max", 64'(outs(0)), 64'd2);
    rlast_pulse(4'd0);
    chk("t4_idle_cycle", 64'(arvalid_o), 64'd0);
    tick();
    chk("t4_third_arvalid", 64'(arvalid_o), 64'd1);
    tick();
    chk("t4_third_done", 64'(sb.size()), 64'd0);
    chk("t4_outs_again", 64'(outs(0)), 64'd2);

    // ARREADY low 5 cycles, then AR handshake together with rlast on id 0.
    do_reset();
    arready_i = 1'b1;
    set_req(0, 2, 32'h0000_5000, 4'd1);
    sb.push_back('{id: 4'd0, addr: 32'h0000_5000, len: 4'd1});
    sb.push_back('{id: 4'd0, addr: 32'h0000_5100, len: 4'd1});
    drive_pins();
    wait_sb(1, 10, "t5_first");
    arready_i = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t5_frozen", 64'({arvalid_o, arid_o, araddr_o, arlen_o}),
          64'({1'b1, 4'd0, 32'h0000_5100, 4'd1}));
      tick();
    end
    arready_i = 1'b1;
    rlast_pulse(4'd0);
    chk("t5_outs_same", 64'(outs(0)), 64'd1);
    chk("t5_credit12", 64'(dut.r_credit), 64'd12);
    chk("t5_no_err", 64'(err_o), 64'd0);

    // Orphan rlast, credit overflow and out-of-range rid all raise the sticky error.
    rlast_pulse(4'd2);
    chk("t6_err_orphan", 64'(err_o), 64'd1);
    tick();
    tick();
    chk("t6_err_sticky", 64'(err_o), 64'd1);
    chk("t6_outs2_zero", 64'(outs(2)), 64'd0);
    do_reset();
    chk("t6_err_cleared", 64'(err_o), 64'd0);
    beat_free_i = 1'b1;
    tick();
    beat_free_i = 1'b0;
    chk("t6_credit_sat", 64'(dut.r_credit), 64'd16);
    chk("t6_err_ovf", 64'(err_o), 64'd1);
    do_reset();
    rlast_pulse(4'd9);
    chk("t6_err_badrid", 64'(err_o), 64'd1);

    // Reset while ARVALID is stalled in ISSUE.
    do_reset();
    set_req(3, 1, 32'h0000_7000, 4'd2);
    drive_pins();
    tick();
    tick();
    chk("t7_issue", 64'(arvalid_o), 64'd1);
    do_reset();
    chk("t7_arvalid0", 64'(arvalid_o), 64'd0);
    chk("t7_credit16", 64'(dut.r_credit), 64'd16);
    chk("t7_payload0", 64'({arid_o, araddr_o, arlen_o}), 64'd0);
    chk("t7_idle", 64'(idle_o), 64'd1);
    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
